// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   sources. Port A (in-order pipeline WB) has fixed priority. Port B
//   (long-latency unit) is forced through after STARVE_LIMIT consecutive
//   lost cycles. Accepted writes appear on the rf_* outputs one cycle later
//   from registers. Writes to x0 are accepted but never drive rf_we.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   a_valid/a_addr/a_data port A request, a_ready = accepted this cycle
//   b_valid/b_addr/b_data port B request, b_ready = accepted this cycle
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   force_b               high while B is being forced (stall hint)
//
// Optional build macro REGFILE_WB_ARB_STATS_EN adds:
//   stat_clr              synchronous clear of both statistics counters
//   stat_conflicts[15:0]  saturating count of cycles with a_valid&&b_valid
//   stat_forced[15:0]     saturating count of entries into the forced state
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              force_b
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced
`endif
);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } state_e;

  // Highest value starve_cnt may hold; one more loss from here forces B.
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                force_b_q, force_b_d;

  logic                a_xfer_s;
  logic                b_xfer_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  // Grant decode and next-state/starvation-counter logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        a_ready = 1'b1;
        b_ready = !a_valid;
        if (a_valid && b_valid) begin
          // B loses this cycle.
          if (starve_cnt_q >= LIMIT_M1) begin
            state_d      = ST_FORCE_B;
            starve_cnt_d = 4'd0;
          end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          // B idle or granted.
          starve_cnt_d = 4'd0;
        end
      end
      ST_FORCE_B: begin
        b_ready = 1'b1;
        // Leave after one cycle whether B transferred or withdrew.
        state_d      = ST_NORMAL;
        starve_cnt_d = 4'd0;
      end
      default: begin
        state_d      = ST_NORMAL;
        starve_cnt_d = 4'd0;
      end
    endcase
  end

  // Write-port mux and next values for the registered outputs.
  always_comb begin
    a_xfer_s   = a_valid && a_ready;
    b_xfer_s   = b_valid && b_ready;
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    if (a_xfer_s) begin
      sel_addr_s = a_addr;
      sel_data_s = a_data;
    end else if (b_xfer_s) begin
      sel_addr_s = b_addr;
      sel_data_s = b_data;
    end else begin
      sel_addr_s = {ADDR_W{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
    end
    // x0 writes complete the handshake but never reach the register file.
    rf_we_d = (a_xfer_s || b_xfer_s) && (sel_addr_s != {ADDR_W{1'b0}});
    if (rf_we_d) begin
      rf_waddr_d = sel_addr_s;
      rf_wdata_d = sel_data_s;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
    force_b_d = (state_d == ST_FORCE_B);
  end

  // State, starvation counter and registered write-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= {ADDR_W{1'b0}};
      rf_wdata_q   <= {DATA_W{1'b0}};
      force_b_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      force_b_q    <= force_b_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign force_b  = force_b_q;

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0] stat_conflicts_q, stat_conflicts_d;
  logic [15:0] stat_forced_q, stat_forced_d;

  // Saturating statistics counters with synchronous clear.
  always_comb begin
    stat_conflicts_d = stat_conflicts_q;
    stat_forced_d    = stat_forced_q;
    if (stat_clr) begin
      stat_conflicts_d = 16'd0;
      stat_forced_d    = 16'd0;
    end else begin
      if (a_valid && b_valid && (stat_conflicts_q != 16'hFFFF)) begin
        stat_conflicts_d = stat_conflicts_q + 16'd1;
      end else begin
        stat_conflicts_d = stat_conflicts_q;
      end
      if ((state_q == ST_NORMAL) && (state_d == ST_FORCE_B) &&
          (stat_forced_q != 16'hFFFF)) begin
        stat_forced_d = stat_forced_q + 16'd1;
      end else begin
        stat_forced_d = stat_forced_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_conflicts_q <= 16'd0;
      stat_forced_q    <= 16'd0;
    end else begin
      stat_conflicts_q <= stat_conflicts_d;
      stat_forced_q    <= stat_forced_d;
    end
  end

  assign stat_conflicts = stat_conflicts_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule
